// File: rtl/pkt_rx_pkg.sv
// pkt_rx_pkg
//   Shared definitions for the packet receiver: error codes reported on
//   err_code, FSM state encoding and the status counter width.
package pkt_rx_pkg;

  localparam int CNT_W = 16;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_HDR    = 3'd1;
  localparam logic [2:0] ERR_LEN    = 3'd2;
  localparam logic [2:0] ERR_CHK    = 3'd3;
  localparam logic [2:0] ERR_TRUNC  = 3'd4;
  localparam logic [2:0] ERR_ORPHAN = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BODY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/pkt_rx_sat_cnt.sv
// sat_cnt
//   Saturating up-counter; holds at all-ones once reached.
//   clk, rst_n : clock, async active-low reset
//   inc        : add one this cycle
//   cnt        : current count
module sat_cnt
  import pkt_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_rx.sv
// pkt_rx
//   Read-side packet checker for the byte FIFO. Validates the length header
//   and XOR checksum of each packet, pulses pkt_ok / pkt_err one cycle after
//   the deciding beat, keeps saturating good/bad counters, and throttles the
//   FIFO with b_rdy for GAP_CYC cycles after every packet end.
//
//   clk, rst_n                 : clock, async active-low reset
//   din, din_vld, din_sop/eop  : byte stream from the FIFO read port
//   rx_hold                    : downstream hold, forces b_rdy low
//   b_rdy                      : ready back to the FIFO
//   pkt_ok, pkt_len            : good-packet pulse and its payload length
//   pkt_err, err_code          : error pulse and its code
//   ok_cnt, err_cnt            : saturating packet counters
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | between packets, waiting for a sop beat
//   ST_BODY    | inside a packet with a legal header, counting beats
//   ST_DISCARD | error already reported, dropping beats up to eop
module pkt_rx
  import pkt_rx_pkg::*;
#(
  parameter int MAX_LEN = 200,
  parameter int GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_vld,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic             rx_hold,
  output logic             b_rdy,
  output logic             pkt_ok,
  output logic             pkt_err,
  output logic [2:0]       err_code,
  output logic [7:0]       pkt_len,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  localparam logic [7:0] GAP_L = 8'(GAP_CYC);

  state_t     state_q, state_d;
  // beats seen so far; reaches L+1 (up to 256) when the checksum beat is due
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] len_q, len_d;
  logic [7:0] xor_q, xor_d;
  logic [7:0] gap_q;
  logic       rep_ok, rep_err, pkt_end;
  logic [2:0] rep_code;
  logic       hdr_bad;
  logic [8:0] last_idx;

  assign hdr_bad  = (din == 8'd0) || (din > MAX_L);
  assign last_idx = {1'b0, len_q} + 9'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    xor_d    = xor_q;
    rep_ok   = 1'b0;
    rep_err  = 1'b0;
    rep_code = ERR_NONE;
    pkt_end  = 1'b0;
    if (din_vld) begin
      if (din_sop && (state_q != ST_IDLE)) begin
        // A new sop cuts the old packet short; TRUNC outranks any header
        // fault on the new packet, which is then silently discarded.
        rep_err  = 1'b1;
        rep_code = ERR_TRUNC;
        if (din_eop) begin
          state_d = ST_IDLE;
        end else if (hdr_bad) begin
          state_d = ST_DISCARD;
        end else begin
          state_d = ST_BODY;
          cnt_d   = 9'd1;
          len_d   = din;
          xor_d   = din;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (din_sop) begin
              if (hdr_bad) begin
                rep_err  = 1'b1;
                rep_code = ERR_HDR;
                state_d  = din_eop ? ST_IDLE : ST_DISCARD;
              end else if (din_eop) begin
                // legal header but the packet ends on it
                rep_err  = 1'b1;
                rep_code = ERR_LEN;
              end else begin
                state_d = ST_BODY;
                cnt_d   = 9'd1;
                len_d   = din;
                xor_d   = din;
              end
            end else if (din_eop) begin
              rep_err  = 1'b1;
              rep_code = ERR_ORPHAN;
            end
          end
          ST_BODY: begin
            if (din_eop) begin
              state_d = ST_IDLE;
              if (cnt_q != last_idx) begin
                rep_err  = 1'b1;
                rep_code = ERR_LEN;
              end else if (xor_q == din) begin
                rep_ok = 1'b1;
              end else begin
                rep_err  = 1'b1;
                rep_code = ERR_CHK;
              end
            end else if (cnt_q == last_idx) begin
              rep_err  = 1'b1;
              rep_code = ERR_LEN;
              state_d  = ST_DISCARD;
            end else begin
              cnt_d = cnt_q + 9'd1;
              xor_d = xor_q ^ din;
            end
          end
          ST_DISCARD: begin
            if (din_eop) begin
              state_d = ST_IDLE;
              pkt_end = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      xor_q    <= '0;
      gap_q    <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= ERR_NONE;
      pkt_len  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      xor_q   <= xor_d;
      pkt_ok  <= rep_ok;
      pkt_err <= rep_err;
      if (rep_err) err_code <= rep_code;
      if (rep_ok)  pkt_len  <= len_q;
      if (rep_ok || rep_err || pkt_end) begin
        gap_q <= GAP_L;
      end else if (gap_q != 8'd0) begin
        gap_q <= gap_q - 8'd1;
      end
    end
  end

  assign b_rdy = (gap_q == 8'd0) && !rx_hold;

  // counters step on the same edge that raises the pulse
  sat_cnt u_ok_cnt  (.clk(clk), .rst_n(rst_n), .inc(rep_ok),  .cnt(ok_cnt));
  sat_cnt u_err_cnt (.clk(clk), .rst_n(rst_n), .inc(rep_err), .cnt(err_cnt));

endmodule

// File: tb/tb_pkt_rx.sv
module tb_pkt_rx;

  localparam int MAX_LEN = 200;
  localparam int GAP_CYC = 4;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [31:0] cyc;
    logic        ok;
    logic        err;
    logic [2:0]  code;
    logic [7:0]  len;
    logic [15:0] okc;
    logic [15:0] errc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_vld, din_sop, din_eop, rx_hold;
  logic        b_rdy, pkt_ok, pkt_err;
  logic [2:0]  err_code;
  logic [7:0]  pkt_len;
  logic [15:0] ok_cnt, err_cnt;

  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_ok = 16'd0;
  logic [15:0] exp_err = 16'd0;
  ev_t         ev_q[$];
  ev_t         exp_q[$];

  pkt_rx #(.MAX_LEN(MAX_LEN), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_sop(din_sop), .din_eop(din_eop), .rx_hold(rx_hold),
    .b_rdy(b_rdy), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .pkt_len(pkt_len),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && (pkt_ok || pkt_err)) begin
      ev_t e;
      e.cyc  = cyc;
      e.ok   = pkt_ok;
      e.err  = pkt_err;
      e.code = pkt_err ? err_code : 3'd0;
      e.len  = pkt_ok ? pkt_len : 8'd0;
      e.okc  = ok_cnt;
      e.errc = err_cnt;
      ev_q.push_back(e);
    end
  end

  // one beat, presented just after a rising edge; c is the cycle it is
  // presented in, so its report is expected in cycle c+1
  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [7:0] d, output int c);
    @(posedge clk);
    #1;
    din_vld = v;
    din_sop = s;
    din_eop = e;
    din     = d;
    c       = cyc;
  endtask

  // idle cycles carry random sop/eop/data that must be ignored
  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), c);
  endtask

  task automatic send(input bq_t q, input bit gaps, input bit with_eop,
                      output int cs[$]);
    int c;
    cs = {};
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 2));
      drive(1'b1, i == 0, with_eop && (i == q.size() - 1), q[i], c);
      cs.push_back(c);
    end
  endtask

  task automatic expect_ev(input int c, input logic [2:0] code, input logic [7:0] len);
    ev_t e;
    e.cyc = c + 1;
    if (code == 3'd0) begin
      if (exp_ok != 16'hFFFF) exp_ok = exp_ok + 16'd1;
      e.ok = 1'b1; e.err = 1'b0; e.code = 3'd0; e.len = len;
    end else begin
      if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      e.ok = 1'b0; e.err = 1'b1; e.code = code; e.len = 8'd0;
    end
    e.okc  = exp_ok;
    e.errc = exp_err;
    exp_q.push_back(e);
  endtask

  function automatic bq_t make_pkt(input int L);
    bq_t q;
    logic [7:0] x;
    q.push_back(8'(L));
    x = 8'(L);
    for (int i = 0; i < L; i++) begin
      q.push_back(8'($urandom));
      x = x ^ q[q.size() - 1];
    end
    q.push_back(x);
    return q;
  endfunction

  // reference outcome of a packet from the format rules alone
  task automatic model(input bq_t q, output logic [2:0] code, output int idx);
    int L, n;
    logic [7:0] x;
    L = int'(q[0]);
    n = q.size();
    if (L == 0 || L > MAX_LEN) begin
      code = 3'd1; idx = 0;
    end else if (n < L + 2) begin
      code = 3'd2; idx = n - 1;
    end else if (n > L + 2) begin
      code = 3'd2; idx = L + 1;
    end else begin
      x = 8'd0;
      foreach (q[i]) x = x ^ q[i];
      code = (x == 8'd0) ? 3'd0 : 3'd3;
      idx = n - 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_hold = 1'b0;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({pkt_ok, pkt_err, err_code, pkt_len, ok_cnt, err_cnt, b_rdy} !== {2'b00, 3'd0, 8'd0, 16'd0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got ok=%b err=%b code=%0d len=%0d okc=%0d errc=%0d rdy=%b, expected zeros with rdy=1",
               pkt_ok, pkt_err, err_code, pkt_len, ok_cnt, err_cnt, b_rdy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good();
    int cs[$];
    int c, k;
    bq_t q;
    logic exp_rdy;
    q = {8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h03 ^ 8'hAA ^ 8'hBB ^ 8'hCC};
    send(q, 1'b0, 1'b1, cs);
    k = cs[4];
    expect_ev(k, 3'd0, 8'd3);
    for (int j = 0; j < 7; j++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, c);
      @(negedge clk);
      exp_rdy = !(c >= k + 1 && c <= k + GAP_CYC);
      n_assert++;
      if (b_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL good_gap cyc+%0d: b_rdy=%b, expected %b", c - k, b_rdy, exp_rdy);
      end
    end
    rx_hold = 1'b1;
    @(negedge clk);
    n_assert++;
    if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_low: b_rdy=%b, expected 0", b_rdy); end
    rx_hold = 1'b0;
    @(negedge clk);
    n_assert++;
    if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL hold_release: b_rdy=%b, expected 1", b_rdy); end
    idle(4);
    n_assert++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL good_evcount: got %0d reports, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < ev_q.size()) ? ev_q[i] : '0;
      n_assert++;
      if (a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL good_ev%0d: got %h, expected %h (cyc|ok|err|code|len|okc|errc)", i, a, exp_q[i]);
      end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    int cs[$];
    int c;
    bq_t q;
    // checksum mismatch
    q = {8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    send(q, 1'b0, 1'b1, cs);
    expect_ev(cs[4], 3'd3, 8'd0);
    idle(6);
    // zero-length header: one report on the header, rest dropped
    q = {8'h00, 8'h11, 8'h22, 8'h33};
    send(q, 1'b0, 1'b1, cs);
    expect_ev(cs[0], 3'd1, 8'd0);
    idle(6);
    // orphans in IDLE: only the eop beat reports
    drive(1'b1, 1'b0, 1'b0, 8'h11, c);
    drive(1'b1, 1'b0, 1'b1, 8'h22, c);
    expect_ev(c, 3'd5, 8'd0);
    idle(6);
    // L=5 packet cut by a valid L=1 packet
    q = {8'h05, 8'hA1, 8'hA2};
    send(q, 1'b0, 1'b0, cs);
    q = {8'h01, 8'h7E, 8'h7F};
    send(q, 1'b0, 1'b1, cs);
    expect_ev(cs[0], 3'd4, 8'd0);
    expect_ev(cs[2], 3'd0, 8'd1);
    idle(6);
    n_assert++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL err_evcount: got %0d reports, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < ev_q.size()) ? ev_q[i] : '0;
      n_assert++;
      if (a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL err_ev%0d: got %h, expected %h (cyc|ok|err|code|len|okc|errc)", i, a, exp_q[i]);
      end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int cs[$];
    bq_t q;
    // each packet starts while b_rdy is already low from the previous one
    for (int p = 0; p < 3; p++) begin
      q = make_pkt(p + 1);
      send(q, 1'b0, 1'b1, cs);
      expect_ev(cs[cs.size() - 1], 3'd0, 8'(p + 1));
    end
    idle(6);
    n_assert++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_evcount: got %0d reports, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < ev_q.size()) ? ev_q[i] : '0;
      n_assert++;
      if (a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_ev%0d: got %h, expected %h (cyc|ok|err|code|len|okc|errc)", i, a, exp_q[i]);
      end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int cs[$];
    bq_t q;
    int kind, L, n, idx;
    logic [2:0] code;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 4);
      L = $urandom_range(1, 12);
      q = make_pkt(L);
      case (kind)
        1: q[L + 1] = q[L + 1] ^ 8'($urandom_range(1, 255));
        2: begin
          n = $urandom_range(1, L + 1);
          while (q.size() > n) void'(q.pop_back());
        end
        3: for (int j = 0; j < $urandom_range(1, 3); j++) q.push_back(8'($urandom));
        4: begin
          q = {};
          q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
          for (int j = 0; j < $urandom_range(0, 3); j++) q.push_back(8'($urandom));
        end
        default: ;
      endcase
      model(q, code, idx);
      send(q, 1'b1, 1'b1, cs);
      expect_ev(cs[idx], code, 8'(L));
      idle($urandom_range(0, 2));
    end
    idle(6);
    n_assert++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_evcount: got %0d reports, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < ev_q.size()) ? ev_q[i] : '0;
      n_assert++;
      if (a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_ev%0d: got %h, expected %h (cyc|ok|err|code|len|okc|errc)", i, a, exp_q[i]);
      end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturate();
    int c, n;
    ev_t last;
    // a run of orphan eop beats reports once per cycle
    n = 65535 - int'(exp_err) + 2;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1, 8'h5A, c);
    idle(4);
    n_assert++;
    if (err_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_err_cnt: err_cnt=%h, expected ffff", err_cnt);
    end
    n_assert++;
    if (ok_cnt !== exp_ok) begin
      n_fail++;
      $display("FAIL sat_ok_cnt: ok_cnt=%0d, expected %0d", ok_cnt, exp_ok);
    end
    n_assert++;
    if (ev_q.size() != n) begin
      n_fail++;
      $display("FAIL sat_evcount: got %0d reports, expected %0d", ev_q.size(), n);
    end
    last = (ev_q.size() > 0) ? ev_q[ev_q.size() - 1] : '0;
    n_assert++;
    if ({last.err, last.code, last.errc} !== {1'b1, 3'd5, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL sat_last: got err=%b code=%0d errc=%h, expected err=1 code=5 errc=ffff",
               last.err, last.code, last.errc);
    end
    exp_err = 16'hFFFF;
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int c;
    drive(1'b1, 1'b1, 1'b0, 8'h03, c);
    drive(1'b1, 1'b0, 1'b0, 8'hAA, c);
    #3;
    rst_n = 1'b0;
    din_vld = 1'b0;
    #1;
    n_assert++;
    if ({pkt_ok, pkt_err, err_code, pkt_len, ok_cnt, err_cnt, b_rdy} !== {2'b00, 3'd0, 8'd0, 16'd0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_values: got ok=%b err=%b code=%0d len=%0d okc=%0d errc=%0d rdy=%b, expected zeros with rdy=1",
               pkt_ok, pkt_err, err_code, pkt_len, ok_cnt, err_cnt, b_rdy);
    end
    exp_ok = 16'd0; exp_err = 16'd0;
    ev_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    // rest of the abandoned packet is now an orphan
    drive(1'b1, 1'b0, 1'b0, 8'hBB, c);
    drive(1'b1, 1'b0, 1'b1, 8'h5F, c);
    expect_ev(c, 3'd5, 8'd0);
    idle(6);
    n_assert++;
    if (ev_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_evcount: got %0d reports, expected %0d", ev_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < ev_q.size()) ? ev_q[i] : '0;
      n_assert++;
      if (a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_ev%0d: got %h, expected %h (cyc|ok|err|code|len|okc|errc)", i, a, exp_q[i]);
      end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good();
    test_errors();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
